detect_faces_var_isqrt: RTL and testbench

//  Downstream consumer of the 32x32->64 unsigned window-statistics multiplier

---
 rtl/detect_faces_var_isqrt_if.sv | 32 +++
 rtl/detect_faces_var_isqrt.sv | 152 +++++++++++++++
 tb/tb_detect_faces_var_isqrt.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/detect_faces_var_isqrt_if.sv
// Operand/result handshake bundle for the variance square-root block.
// Latency: none (wires only).
// Backpressure: in_ready throttles the producer, out_ready throttles the result.
// Ports (signals):
//   in_valid/in_ready   operand-pair handshake
//   prod_a/prod_b       sq_sum*area and sum*sum, unsigned, IN_WIDTH bits
//   out_valid/out_ready result handshake
//   stddev              integer square root of the clamped variance
//   clamped             prod_b exceeded prod_a, so the variance was forced to 0
interface detect_faces_var_isqrt_if #(
  parameter int IN_WIDTH  = 64,
  parameter int OUT_WIDTH = IN_WIDTH / 2
);
  logic                 in_valid;
  logic                 in_ready;
  logic [IN_WIDTH-1:0]  prod_a;
  logic [IN_WIDTH-1:0]  prod_b;
  logic                 out_valid;
  logic                 out_ready;
  logic [OUT_WIDTH-1:0] stddev;
  logic                 clamped;

  modport master (
    output in_valid, prod_a, prod_b, out_ready,
    input  in_ready, out_valid, stddev, clamped
  );

  modport slave (
    input  in_valid, prod_a, prod_b, out_ready,
    output in_ready, out_valid, stddev, clamped
  );
endinterface

// File: rtl/detect_faces_var_isqrt.sv
// Variance (prod_a - prod_b, clamped at 0) followed by a digit-serial integer sqrt.
// Latency: accept edge T -> out_valid after edge T+N+1 (N+2 with rounding), N = OUT_WIDTH/BITS_PER_CYCLE.
// Backpressure: one operation in flight; in_ready=0 until the result is taken, result held until out_ready.
// Ports:
//   clk    rising-edge clock
//   reset  synchronous, active-high; aborts any operation and drops the result
//   bus    detect_faces_var_isqrt_if.slave (operand and result handshakes)
// Build option: define DETECT_FACES_VAR_ISQRT_ROUND_EN to round the root to nearest
//   (saturating) at the cost of one extra cycle; undefined gives floor(sqrt(var)).
module detect_faces_var_isqrt #(
  parameter int IN_WIDTH       = 64,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  detect_faces_var_isqrt_if.slave bus
);
  localparam int OUT_WIDTH = IN_WIDTH / 2;
  localparam int N         = OUT_WIDTH / BITS_PER_CYCLE;
  localparam int CW        = $clog2(N + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_DONE
  } state_t;

  state_t               r_state;
  state_t               w_next;
  logic [IN_WIDTH-1:0]  r_var;
  logic [OUT_WIDTH+1:0] r_rem;
  logic [OUT_WIDTH-1:0] r_root;
  logic [CW-1:0]        r_cnt;
  logic [OUT_WIDTH-1:0] r_stddev;
  logic                 r_clamped;
  logic                 r_out_valid;
  logic                 w_in_ready;
`ifdef DETECT_FACES_VAR_ISQRT_ROUND_EN
  logic                 r_rnd_done;
`endif

  // One extra bit so the borrow out of the subtract flags prod_b > prod_a.
  logic [IN_WIDTH:0]    w_diff;
  assign w_diff = {1'b0, bus.prod_a} - {1'b0, bus.prod_b};

  // BITS_PER_CYCLE restoring sqrt steps unrolled: each pulls two var bits into rem.
  logic [IN_WIDTH-1:0]  w_var_n;
  logic [OUT_WIDTH+1:0] w_rem_n;
  logic [OUT_WIDTH-1:0] w_root_n;
  logic [OUT_WIDTH+1:0] w_trial;

  always_comb begin
    w_var_n  = r_var;
    w_rem_n  = r_rem;
    w_root_n = r_root;
    w_trial  = '0;
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      // rem <= 2*root before the shift, so OUT_WIDTH+2 bits always hold it.
      w_rem_n = {w_rem_n[OUT_WIDTH-1:0], w_var_n[IN_WIDTH-1 -: 2]};
      w_var_n = {w_var_n[IN_WIDTH-3:0], 2'b00};
      w_trial = {w_root_n, 2'b01};
      if (w_rem_n >= w_trial) begin
        w_rem_n  = w_rem_n - w_trial;
        w_root_n = {w_root_n[OUT_WIDTH-2:0], 1'b1};
      end else begin
        w_root_n = {w_root_n[OUT_WIDTH-2:0], 1'b0};
      end
    end
  end

  always_comb begin
    w_next     = r_state;
    w_in_ready = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_in_ready = !reset;
        if (bus.in_valid) w_next = S_CALC;
      end
      S_CALC: begin
        if (r_cnt == CW'(1)) w_next = S_DONE;
      end
      S_DONE: begin
        if (r_out_valid && bus.out_ready) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_var       <= '0;
      r_rem       <= '0;
      r_root      <= '0;
      r_cnt       <= '0;
      r_stddev    <= '0;
      r_clamped   <= 1'b0;
      r_out_valid <= 1'b0;
`ifdef DETECT_FACES_VAR_ISQRT_ROUND_EN
      r_rnd_done  <= 1'b0;
`endif
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE: begin
          if (bus.in_valid) begin
            r_var     <= w_diff[IN_WIDTH] ? '0 : w_diff[IN_WIDTH-1:0];
            r_clamped <= w_diff[IN_WIDTH];
            r_rem     <= '0;
            r_root    <= '0;
            r_cnt     <= CW'(N);
`ifdef DETECT_FACES_VAR_ISQRT_ROUND_EN
            r_rnd_done <= 1'b0;
`endif
          end
        end
        S_CALC: begin
          r_var  <= w_var_n;
          r_rem  <= w_rem_n;
          r_root <= w_root_n;
          r_cnt  <= r_cnt - CW'(1);
        end
        S_DONE: begin
          // The first DONE cycle(s) publish the root; the result then holds until taken.
          if (!r_out_valid) begin
`ifdef DETECT_FACES_VAR_ISQRT_ROUND_EN
            if (!r_rnd_done) begin
              // var >= (root+0.5)^2 reduces to rem > root; all-ones root saturates.
              r_rnd_done <= 1'b1;
              if ((r_rem > {2'b00, r_root}) && !(&r_root)) r_root <= r_root + 1'b1;
            end else begin
              r_stddev    <= r_root;
              r_out_valid <= 1'b1;
            end
`else
            r_stddev    <= r_root;
            r_out_valid <= 1'b1;
`endif
          end else if (bus.out_ready) begin
            r_out_valid <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.stddev    = r_stddev;
  assign bus.clamped   = r_clamped;
endmodule

// File: tb/tb_detect_faces_var_isqrt.sv
// Bench for detect_faces_var_isqrt: three instances (1, 2 and 4 root bits per cycle)
// driven with identical operands, expected results queued at drive time.
module tb_detect_faces_var_isqrt;
  localparam int NDUT = 3;
`ifdef DETECT_FACES_VAR_ISQRT_ROUND_EN
  localparam int RND = 1;
`else
  localparam int RND = 0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        out_ready;
  logic [63:0] prod_a;
  logic [63:0] prod_b;

  logic [NDUT-1:0] w_in_ready;
  logic [NDUT-1:0] w_out_valid;
  logic [NDUT-1:0] w_clamped;
  logic [31:0]     w_stddev [NDUT];

  always #5 clk = ~clk;

  for (genvar k = 0; k < NDUT; k++) begin : g
    detect_faces_var_isqrt_if #(.IN_WIDTH(64)) bus ();
    assign bus.in_valid  = in_valid;
    assign bus.prod_a    = prod_a;
    assign bus.prod_b    = prod_b;
    assign bus.out_ready = out_ready;
    assign w_in_ready[k]  = bus.in_ready;
    assign w_out_valid[k] = bus.out_valid;
    assign w_clamped[k]   = bus.clamped;
    assign w_stddev[k]    = bus.stddev;
    detect_faces_var_isqrt #(
      .IN_WIDTH      (64),
      .BITS_PER_CYCLE(1 << k)
    ) u_dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
    );
  end

  typedef struct packed {
    logic [31:0] sd;
    logic        cl;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic chk(input string tag, input int k, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s dut%0d observed=%0h expected=%0h", tag, k, obs, exp);
    end
  endtask

  function automatic int exp_lat(input int k);
    return (32 >> k) + 1 + RND;
  endfunction

  // Drive one operand pair, check latency, hold for `hold` cycles, then take the result.
  task automatic do_op(input logic [63:0] a, input logic [63:0] b,
                       input logic [31:0] e_floor, input logic [31:0] e_round,
                       input logic e_cl, input int hold);
    exp_t            e;
    exp_t            got;
    logic [NDUT-1:0] seen;
    int              lat;
    @(negedge clk);
    prod_a   = a;
    prod_b   = b;
    in_valid = 1'b1;
    e.sd     = (RND != 0) ? e_round : e_floor;
    e.cl     = e_cl;
    sb.push_back(e);
    for (int k = 0; k < NDUT; k++) chk("idle_rdy", k, 64'(w_in_ready[k]), 64'd1);
    @(posedge clk);
    @(negedge clk);
    // Busy: a different operand stays offered and out_ready pulses with no result pending.
    prod_a    = '1;
    prod_b    = '0;
    out_ready = 1'b1;
    for (int k = 0; k < NDUT; k++) chk("busy_rdy", k, 64'(w_in_ready[k]), 64'd0);
    seen = '0;
    lat  = 0;
    while (seen != '1 && lat < 64) begin
      for (int k = 0; k < NDUT; k++) begin
        if (w_out_valid[k] && !seen[k]) begin
          seen[k] = 1'b1;
          chk("latency", k, 64'(lat), 64'(exp_lat(k)));
        end
      end
      if (seen != '1) begin
        @(negedge clk);
        lat++;
        out_ready = 1'b0;
      end
    end
    for (int k = 0; k < NDUT; k++) if (!seen[k]) chk("timeout", k, 64'd0, 64'd1);
    repeat (hold) begin
      @(negedge clk);
      for (int k = 0; k < NDUT; k++) begin
        chk("hold_vld", k, 64'(w_out_valid[k]), 64'd1);
        chk("hold_sd", k, 64'(w_stddev[k]), 64'(e.sd));
        chk("hold_rdy", k, 64'(w_in_ready[k]), 64'd0);
      end
    end
    got = sb.pop_front();
    for (int k = 0; k < NDUT; k++) begin
      chk("stddev", k, 64'(w_stddev[k]), 64'(got.sd));
      chk("clamped", k, 64'(w_clamped[k]), 64'(got.cl));
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    for (int k = 0; k < NDUT; k++) begin
      chk("post_vld", k, 64'(w_out_valid[k]), 64'd0);
      chk("post_rdy", k, 64'(w_in_ready[k]), 64'd1);
    end
  endtask

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    prod_a    = '0;
    prod_b    = '0;
    repeat (3) @(negedge clk);
    for (int k = 0; k < NDUT; k++) begin
      chk("rst_rdy", k, 64'(w_in_ready[k]), 64'd0);
      chk("rst_vld", k, 64'(w_out_valid[k]), 64'd0);
      chk("rst_sd", k, 64'(w_stddev[k]), 64'd0);
      chk("rst_cl", k, 64'(w_clamped[k]), 64'd0);
    end
    reset = 1'b0;
    #1;
    for (int k = 0; k < NDUT; k++) chk("rel_rdy", k, 64'(w_in_ready[k]), 64'd1);

    do_op(64'd100, 64'd36, 32'd8, 32'd8, 1'b0, 0);
    do_op(64'd24, 64'd0, 32'd4, 32'd5, 1'b0, 0);
    do_op(64'd10, 64'd20, 32'd0, 32'd0, 1'b1, 0);
    do_op(64'd20, 64'd20, 32'd0, 32'd0, 1'b0, 0);
    do_op(64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 0);
    do_op(64'd3, 64'd0, 32'd1, 32'd2, 1'b0, 0);
    do_op(64'd1000000, 64'd0, 32'd1000, 32'd1000, 1'b0, 10);

    // Reset in the middle of an operation drops it entirely.
    @(negedge clk);
    prod_a   = 64'd100;
    prod_b   = 64'd36;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (11) @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    for (int k = 0; k < NDUT; k++) begin
      chk("abort_vld", k, 64'(w_out_valid[k]), 64'd0);
      chk("abort_sd", k, 64'(w_stddev[k]), 64'd0);
      chk("abort_rdy", k, 64'(w_in_ready[k]), 64'd0);
    end
    @(negedge clk);
    reset = 1'b0;
    #1;
    for (int k = 0; k < NDUT; k++) chk("abort_rel_rdy", k, 64'(w_in_ready[k]), 64'd1);
    do_op(64'd49, 64'd0, 32'd7, 32'd7, 1'b0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
